// File: rtl/any1_pkg.sv
// rtl/any1_pkg.sv - shared PTE/TLB-entry types, walker states and fault causes
// Contents:
//   pte_t        64-bit page-table entry as read from memory
//   tlb_entry_t  64-bit TLB entry, same layout the TLB itself uses
//   ptw_cause_e  walker fault cause reported on cause_o
//   ptw_state_e  walker FSM states
//   mk_tlbe()    formats a leaf PTE into a TLB entry (A/D cleared)
package any1_pkg;

    // Leaf PTE: ppn = [31:14]. A table-pointer PTE reuses [31:13] as the
    // 8 kB-aligned base of the next-level table, i.e. {ppn, rsvd[5]}.
    typedef struct packed {
        logic [31:0] hi;
        logic [17:0] ppn;
        logic [5:0]  rsvd;
        logic        d;
        logic        a;
        logic        g;
        logic        c;
        logic        r;
        logic        w;
        logic        x;
        logic        v;
    } pte_t;

    // Permission bits sit at the same positions as in the PTE so that
    // formatting an entry is a field copy.
    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  asid;
        logic [7:0]  vpn;
        logic [17:0] ppn;
        logic [5:0]  rsvd_lo;
        logic        d;
        logic        a;
        logic        g;
        logic        c;
        logic        r;
        logic        w;
        logic        x;
        logic        rsvd0;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        CAUSE_INVALID = 2'd0,
        CAUSE_BAD_PTR = 2'd1,
        CAUSE_BUS_ERR = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } ptw_cause_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_L1   = 3'd1,
        S_L2   = 3'd2,
        S_WR   = 3'd3,
        S_FIN  = 3'd4
    } ptw_state_e;

    // A and D start cleared; the TLB sets them when the entry is used.
    function automatic logic [63:0] mk_tlbe(input pte_t pte, input logic [7:0] vpn,
                                            input logic [7:0] asid);
        tlb_entry_t e;
        e      = '0;
        e.asid = asid;
        e.vpn  = vpn;
        e.ppn  = pte.ppn;
        e.g    = pte.g;
        e.c    = pte.c;
        e.r    = pte.r;
        e.w    = pte.w;
        e.x    = pte.x;
        e.a    = 1'b0;
        e.d    = 1'b0;
        return e;
    endfunction

endpackage

// File: rtl/any1_ptw_busif.sv
// rtl/any1_ptw_busif.sv - single-beat read master with timeout for the page-table walker
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i, start_adr_i     begin a read at start_adr_i next cycle
//   ack_i, err_i             bus response (err wins over ack)
//   cyc_o, stb_o, adr_o      registered bus request
//   rd_done_o                read completed this cycle (dat_i valid)
//   rd_err_o                 read ended with a bus error this cycle
//   rd_tmo_o                 read abandoned after TMO strobe cycles
module any1_ptw_busif #(
    parameter int AWID = 32,
    parameter int TMO  = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [AWID-1:0] start_adr_i,
    input  logic            ack_i,
    input  logic            err_i,
    output logic            cyc_o,
    output logic            stb_o,
    output logic [AWID-1:0] adr_o,
    output logic            rd_done_o,
    output logic            rd_err_o,
    output logic            rd_tmo_o
);

    localparam int            CW       = (TMO > 1) ? $clog2(TMO + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST = (TMO > 0) ? CW'(TMO - 1) : '0;

    logic            stb_q, stb_d;
    logic [AWID-1:0] adr_q, adr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_comb begin
        stb_d     = stb_q;
        adr_d     = adr_q;
        cnt_d     = cnt_q;
        rd_done_o = 1'b0;
        rd_err_o  = 1'b0;
        rd_tmo_o  = 1'b0;
        if (stb_q) begin
            if (err_i) begin
                rd_err_o = 1'b1;
                stb_d    = 1'b0;
            end else if (ack_i) begin
                rd_done_o = 1'b1;
                stb_d     = 1'b0;
            end else if ((TMO != 0) && (cnt_q == TMO_LAST)) begin
                // cnt_q counts strobe cycles already spent without a response
                rd_tmo_o = 1'b1;
                stb_d    = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        // A new read may be launched in the same cycle the previous one ends,
        // so the next level follows with no strobe gap.
        if (start_i) begin
            stb_d = 1'b1;
            adr_d = start_adr_i;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stb_q <= 1'b0;
            adr_q <= '0;
            cnt_q <= '0;
        end else begin
            stb_q <= stb_d;
            adr_q <= adr_d;
            cnt_q <= cnt_d;
        end
    end

    assign cyc_o = stb_q;
    assign stb_o = stb_q;
    assign adr_o = adr_q;

endmodule

// File: rtl/any1_ptw.sv
// rtl/any1_ptw.sv - two-level page-table walker that refills the TLB after a miss
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   miss_i, vadr_i, asid_i, ptbr_i miss request and its context
//   flush_i                        abort the walk
//   busy_o, done_o, fault_o,       walk status; done/fault are one-cycle pulses
//   cause_o                        fault cause, valid with fault_o
//   cyc_o, stb_o, adr_o, dat_i,    64-bit read-only bus master
//   ack_i, err_i
//   tlben_o, wrtlb_o, tlbadr_o,    TLB management write port
//   tlbdat_o
module any1_ptw
    import any1_pkg::*;
#(
    parameter int AWID = 32,
    parameter int TMO  = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            miss_i,
    input  logic [AWID-1:0] vadr_i,
    input  logic [7:0]      asid_i,
    input  logic [AWID-1:0] ptbr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            fault_o,
    output logic [1:0]      cause_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic [AWID-1:0] adr_o,
    input  logic [63:0]     dat_i,
    input  logic            ack_i,
    input  logic            err_i,
    output logic            tlben_o,
    output logic            wrtlb_o,
    output logic [15:0]     tlbadr_o,
    output logic [63:0]     tlbdat_o
);

    ptw_state_e       state_q, state_d;
    logic [AWID-1:14] vadr_q, vadr_d;
    logic [7:0]       asid_q, asid_d;
    logic [AWID-1:12] ptbr_q, ptbr_d;
    logic             abort_q, abort_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    ptw_cause_e       cause_q, cause_d;
    logic             wr_q, wr_d;
    logic [15:0]      tlbadr_q, tlbadr_d;
    logic [63:0]      tlbdat_q, tlbdat_d;

    logic             rd_start;
    logic [AWID-1:0]  rd_adr;
    logic             rd_done, rd_err, rd_tmo, rd_end;
    pte_t             pte_rd;

    // Page offset and the low PTBR bits never take part in the walk.
    logic unused_bits;
    assign unused_bits = &{1'b0, vadr_i[13:0], ptbr_i[11:0]};

    assign pte_rd = pte_t'(dat_i);
    assign rd_end = rd_done | rd_err | rd_tmo;

    any1_ptw_busif #(
        .AWID(AWID),
        .TMO (TMO)
    ) u_busif (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (rd_start),
        .start_adr_i(rd_adr),
        .ack_i      (ack_i),
        .err_i      (err_i),
        .cyc_o      (cyc_o),
        .stb_o      (stb_o),
        .adr_o      (adr_o),
        .rd_done_o  (rd_done),
        .rd_err_o   (rd_err),
        .rd_tmo_o   (rd_tmo)
    );

    always_comb begin
        state_d  = state_q;
        vadr_d   = vadr_q;
        asid_d   = asid_q;
        ptbr_d   = ptbr_q;
        abort_d  = abort_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        fault_d  = 1'b0;
        cause_d  = cause_q;
        wr_d     = 1'b0;
        tlbadr_d = tlbadr_q;
        tlbdat_d = tlbdat_q;
        rd_start = 1'b0;
        rd_adr   = '0;

        unique case (state_q)
            S_IDLE: begin
                if (miss_i && !flush_i) begin
                    vadr_d   = vadr_i[AWID-1:14];
                    asid_d   = asid_i;
                    ptbr_d   = ptbr_i[AWID-1:12];
                    abort_d  = 1'b0;
                    busy_d   = 1'b1;
                    rd_start = 1'b1;
                    // 256-entry L1 table occupies the low 2 kB of the
                    // 4 kB-aligned page at PTBR.
                    rd_adr   = {ptbr_i[AWID-1:12], 1'b0, vadr_i[31:24], 3'b000};
                    state_d  = S_L1;
                end
            end
            S_L1, S_L2: begin
                if (flush_i) begin
                    abort_d = 1'b1;
                end
                if (rd_end) begin
                    // A flush in the completing cycle counts as an abort too.
                    if (abort_q || flush_i) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else if (rd_err) begin
                        fault_d = 1'b1;
                        cause_d = CAUSE_BUS_ERR;
                    end else if (rd_tmo) begin
                        fault_d = 1'b1;
                        cause_d = CAUSE_TIMEOUT;
                    end else if (!pte_rd.v) begin
                        fault_d = 1'b1;
                        cause_d = CAUSE_INVALID;
                    end else if ((state_q == S_L1) && (pte_rd.r || pte_rd.w || pte_rd.x)) begin
                        // Superpages are not supported: an L1 leaf is malformed.
                        fault_d = 1'b1;
                        cause_d = CAUSE_BAD_PTR;
                    end else if (state_q == S_L1) begin
                        rd_start = 1'b1;
                        rd_adr   = {dat_i[AWID-1:13], vadr_q[23:14], 3'b000};
                        state_d  = S_L2;
                    end else begin
                        wr_d     = 1'b1;
                        tlbadr_d = {1'b1, 5'b00000, vadr_q[23:14]};
                        tlbdat_d = mk_tlbe(pte_rd, vadr_q[31:24], asid_q);
                        state_d  = S_WR;
                    end
                end
            end
            S_WR: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        if (fault_d) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            vadr_q   <= '0;
            asid_q   <= '0;
            ptbr_q   <= '0;
            abort_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            cause_q  <= CAUSE_INVALID;
            wr_q     <= 1'b0;
            tlbadr_q <= '0;
            tlbdat_q <= '0;
        end else begin
            state_q  <= state_d;
            vadr_q   <= vadr_d;
            asid_q   <= asid_d;
            ptbr_q   <= ptbr_d;
            abort_q  <= abort_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            cause_q  <= cause_d;
            wr_q     <= wr_d;
            tlbadr_q <= tlbadr_d;
            tlbdat_q <= tlbdat_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign fault_o  = fault_q;
    assign cause_o  = cause_q;
    assign tlben_o  = wr_q;
    assign wrtlb_o  = wr_q;
    assign tlbadr_o = tlbadr_q;
    assign tlbdat_o = tlbdat_q;

endmodule
